// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-code-modulated bit planes.
// Fetches one pixel pair per column from a 1-cycle-latency frame buffer,
// shifts a full row per plane, latches it and lights it for BASE_TICKS<<plane
// cycles scaled by a global brightness.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | stopped, panel blanked, waiting for enable
// FETCH   | read strobe for pixel (col, cur_row)
// LOAD    | frame-buffer data valid, put plane bits on rgb1/rgb2
// CLK     | shift clock high, advance column
// BLANK   | row shifted in, panel blanked ahead of the latch
// LATCH   | latch pulse, drive new row address, capture on-time
// DISPLAY | bit-plane window; oe low for the first ON cycles
// NEXT    | advance plane / row / frame
module hub75_bcm_driver #(
    parameter int COLS       = 64,
    parameter int SCAN_ROWS  = 32,
    parameter int COLOR_BITS = 8,
    parameter int BASE_TICKS = 4,
    localparam int ROW_BITS  = $clog2(SCAN_ROWS),
    localparam int COL_BITS  = $clog2(COLS)
) (
    input  logic                    clk_27MHz,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [7:0]              brightness,
    output logic                    pix_rd_en,
    output logic [COL_BITS-1:0]     pix_addr_x,
    output logic [ROW_BITS-1:0]     pix_addr_y,
    input  logic [3*COLOR_BITS-1:0] pix_top,
    input  logic [3*COLOR_BITS-1:0] pix_bot,
    output logic [2:0]              rgb1,
    output logic [2:0]              rgb2,
    output logic [ROW_BITS-1:0]     row,
    output logic                    sclk,
    output logic                    latch,
    output logic                    oe,
    output logic                    frame_done
);

    localparam int PL_BITS = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int W_MAX   = BASE_TICKS << (COLOR_BITS - 1);
    localparam int DW      = $clog2(W_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_CLK, S_BLANK, S_LATCH, S_DISPLAY, S_NEXT
    } state_t;

    state_t                state_q, state_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [ROW_BITS-1:0]   cur_row_q, cur_row_d;
    logic [PL_BITS-1:0]    plane_q, plane_d;
    logic [DW-1:0]         disp_cnt_q, disp_cnt_d;
    logic [DW-1:0]         on_q, on_d;
    logic [2:0]            rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [COL_BITS-1:0]   addr_x_q, addr_x_d;
    logic [ROW_BITS-1:0]   addr_y_q, addr_y_d;
    logic                  rd_q, rd_d, sclk_q, sclk_d, latch_q, latch_d;
    logic                  oe_q, oe_d, done_q, done_d;

    logic [DW-1:0]         win;
    logic [8:0]            bright_p1;
    logic [DW+7:0]         prod;
    logic [COLOR_BITS-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;

    assign {top_b, top_g, top_r} = pix_top;
    assign {bot_b, bot_g, bot_r} = pix_bot;

    // Next-state, counters and registered panel outputs for the coming cycle
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cur_row_d  = cur_row_q;
        plane_d    = plane_q;
        disp_cnt_d = '0;
        on_d       = on_q;
        rgb1_d     = rgb1_q;
        rgb2_d     = rgb2_q;
        row_d      = row_q;
        addr_x_d   = addr_x_q;
        addr_y_d   = addr_y_q;
        win        = DW'(BASE_TICKS) << plane_q;
        bright_p1  = {1'b0, brightness} + 9'd1;
        prod       = {8'd0, win} * {{(DW-1){1'b0}}, bright_p1};

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_FETCH;
                    col_d     = '0;
                    cur_row_d = '0;
                    plane_d   = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                rgb1_d  = {top_b[plane_q], top_g[plane_q], top_r[plane_q]};
                rgb2_d  = {bot_b[plane_q], bot_g[plane_q], bot_r[plane_q]};
                state_d = S_CLK;
            end
            S_CLK: begin
                if (col_q == COL_BITS'(COLS - 1)) begin
                    col_d   = '0;
                    state_d = S_BLANK;
                end else begin
                    col_d   = col_q + COL_BITS'(1);
                    state_d = S_FETCH;
                end
            end
            S_BLANK: begin
                // brightness is captured on the edge that enters LATCH
                on_d    = DW'(prod >> 8);
                state_d = S_LATCH;
            end
            S_LATCH: state_d = S_DISPLAY;
            S_DISPLAY: begin
                disp_cnt_d = disp_cnt_q + DW'(1);
                if (disp_cnt_q == win - DW'(1))
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = S_FETCH;
                if (plane_q != PL_BITS'(COLOR_BITS - 1)) begin
                    plane_d = plane_q + PL_BITS'(1);
                end else begin
                    plane_d = '0;
                    if (cur_row_q != ROW_BITS'(SCAN_ROWS - 1)) begin
                        cur_row_d = cur_row_q + ROW_BITS'(1);
                    end else begin
                        cur_row_d = '0;
                        if (!enable)
                            state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered against the state they will accompany
        rd_d    = (state_d == S_FETCH);
        sclk_d  = (state_d == S_CLK);
        latch_d = (state_d == S_LATCH);
        oe_d    = !((state_d == S_DISPLAY) && (disp_cnt_d < on_d));
        done_d  = (state_d == S_NEXT) && (plane_q == PL_BITS'(COLOR_BITS - 1))
                  && (cur_row_q == ROW_BITS'(SCAN_ROWS - 1));
        if (state_d == S_FETCH) begin
            addr_x_d = col_d;
            addr_y_d = cur_row_d;
        end
        if (state_d == S_LATCH)
            row_d = cur_row_q;
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge clk_27MHz) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            cur_row_q  <= '0;
            plane_q    <= '0;
            disp_cnt_q <= '0;
            on_q       <= '0;
            rgb1_q     <= '0;
            rgb2_q     <= '0;
            row_q      <= '0;
            addr_x_q   <= '0;
            addr_y_q   <= '0;
            rd_q       <= 1'b0;
            sclk_q     <= 1'b0;
            latch_q    <= 1'b0;
            oe_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            cur_row_q  <= cur_row_d;
            plane_q    <= plane_d;
            disp_cnt_q <= disp_cnt_d;
            on_q       <= on_d;
            rgb1_q     <= rgb1_d;
            rgb2_q     <= rgb2_d;
            row_q      <= row_d;
            addr_x_q   <= addr_x_d;
            addr_y_q   <= addr_y_d;
            rd_q       <= rd_d;
            sclk_q     <= sclk_d;
            latch_q    <= latch_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
        end
    end

    // Frame-buffer data only arrives in LOAD, so serial data is passed through
    // there and held afterwards; it is settled well before sclk rises in CLK.
    assign rgb1       = (state_q == S_LOAD) ? rgb1_d : rgb1_q;
    assign rgb2       = (state_q == S_LOAD) ? rgb2_d : rgb2_q;
    assign pix_rd_en  = rd_q;
    assign pix_addr_x = addr_x_q;
    assign pix_addr_y = addr_y_q;
    assign row        = row_q;
    assign sclk       = sclk_q;
    assign latch      = latch_q;
    assign oe         = oe_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver on a 4x(2x2) panel, 2 bit planes.
// Cycle t=0 is the first FETCH cycle after leaving IDLE. Per plane:
// shift t..t+11, BLANK +12, LATCH +13, DISPLAY +14.., NEXT; a frame is 72 cycles.
module tb_hub75_bcm_driver;

    logic       clk_27MHz;
    logic       rst, enable;
    logic [7:0] brightness;
    logic       pix_rd_en;
    logic [1:0] pix_addr_x;
    logic [0:0] pix_addr_y;
    logic [5:0] pix_top, pix_bot;
    logic [2:0] rgb1, rgb2;
    logic [0:0] row;
    logic       sclk, latch, oe, frame_done;

    int n_pass  = 0;
    int n_total = 0;

    logic [5:0] fb_top [8];
    logic [5:0] fb_bot [8];

    logic       lg_oe [256], lg_latch [256], lg_sclk [256], lg_rd [256], lg_done [256];
    logic [2:0] lg_rgb1 [256], lg_rgb2 [256];
    logic [0:0] lg_row [256], lg_y [256];
    logic [1:0] lg_x [256];

    hub75_bcm_driver #(
        .COLS(4), .SCAN_ROWS(2), .COLOR_BITS(2), .BASE_TICKS(2)
    ) dut (
        .clk_27MHz (clk_27MHz),
        .rst       (rst),
        .enable    (enable),
        .brightness(brightness),
        .pix_rd_en (pix_rd_en),
        .pix_addr_x(pix_addr_x),
        .pix_addr_y(pix_addr_y),
        .pix_top   (pix_top),
        .pix_bot   (pix_bot),
        .rgb1      (rgb1),
        .rgb2      (rgb2),
        .row       (row),
        .sclk      (sclk),
        .latch     (latch),
        .oe        (oe),
        .frame_done(frame_done)
    );

    initial clk_27MHz = 1'b0;
    always #5 clk_27MHz = ~clk_27MHz;

    // Synchronous frame buffer, one cycle read latency
    always @(posedge clk_27MHz) begin
        if (pix_rd_en) begin
            pix_top <= fb_top[{pix_addr_y, pix_addr_x}];
            pix_bot <= fb_bot[{pix_addr_y, pix_addr_x}];
        end
    end

    task automatic step();
        @(posedge clk_27MHz);
        #1;
    endtask

    task automatic fb_fill(input logic [5:0] vt, input logic [5:0] vb);
        for (int i = 0; i < 8; i++) begin
            fb_top[i] = vt;
            fb_bot[i] = vb;
        end
    endtask

    task automatic log_cycle(input int t);
        lg_oe[t] = oe; lg_latch[t] = latch; lg_sclk[t] = sclk; lg_rd[t] = pix_rd_en;
        lg_done[t] = frame_done; lg_rgb1[t] = rgb1; lg_rgb2[t] = rgb2;
        lg_row[t] = row; lg_x[t] = pix_addr_x; lg_y[t] = pix_addr_y;
    endtask

    task automatic start_run(input logic [7:0] br);
        rst = 1'b1; enable = 1'b0; brightness = br;
        step(); step();
        rst = 1'b0; enable = 1'b1;
        step();
    endtask

    task automatic run_log(input int n);
        for (int t = 0; t < n; t++) begin
            log_cycle(t);
            step();
        end
    endtask

    function automatic int count_low_oe(input int a, input int b);
        int c = 0;
        for (int t = a; t <= b; t++) if (lg_oe[t] === 1'b0) c++;
        return c;
    endfunction

    function automatic int count_rd(input int a, input int b);
        int c = 0;
        for (int t = a; t <= b; t++) if (lg_rd[t] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; brightness = 8'd0;
        step(); step();
        n_total++; if ({oe, latch, sclk, pix_rd_en, frame_done} !== 5'b10000)
            $display("FAIL reset_ctrl got oe/latch/sclk/rd/done=%b want 10000", {oe, latch, sclk, pix_rd_en, frame_done}); else n_pass++;
        n_total++; if ({rgb1, rgb2, row, pix_addr_x, pix_addr_y} !== 10'd0)
            $display("FAIL reset_data got rgb1=%b rgb2=%b row=%0d x=%0d y=%0d want all 0", rgb1, rgb2, row, pix_addr_x, pix_addr_y); else n_pass++;
        rst = 1'b0;
        step(); step(); step();
        n_total++; if ({oe, pix_rd_en} !== 2'b10)
            $display("FAIL idle_hold got oe=%b rd=%b want oe=1 rd=0", oe, pix_rd_en); else n_pass++;
    endtask

    task automatic test_frame_timing();
        int first_latch, first_done, n_done, n_latch, n_rgb2;
        fb_fill(6'd0, 6'd0);
        fb_top[1] = 6'b000010;
        start_run(8'd255);
        run_log(80);
        first_latch = -1; first_done = -1; n_done = 0; n_latch = 0; n_rgb2 = 0;
        for (int t = 0; t < 80; t++) begin
            if (lg_latch[t] === 1'b1 && first_latch < 0) first_latch = t;
            if (lg_done[t] === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = t;
            end
            if (t < 72 && lg_latch[t] === 1'b1) n_latch++;
            if (lg_rgb2[t] !== 3'b000) n_rgb2++;
        end
        n_total++; if (first_latch != 13) $display("FAIL first_latch got t=%0d want 13", first_latch); else n_pass++;
        n_total++; if (count_low_oe(0, 13) != 0) $display("FAIL oe_during_shift got %0d low cycles want 0", count_low_oe(0, 13)); else n_pass++;
        n_total++; if (count_low_oe(14, 16) != 2) $display("FAIL oe_plane0 got %0d low cycles want 2", count_low_oe(14, 16)); else n_pass++;
        n_total++; if (count_low_oe(17, 35) != 4) $display("FAIL oe_plane1 got %0d low cycles want 4", count_low_oe(17, 35)); else n_pass++;
        n_total++; if (first_done != 71 || n_done != 1) $display("FAIL frame_done got first=%0d count=%0d want 71/1", first_done, n_done); else n_pass++;
        n_total++; if (n_latch != 4) $display("FAIL latch_count got %0d want 4", n_latch); else n_pass++;
        n_total++; if ({lg_rd[72], lg_x[72], lg_y[72]} !== 4'b1000)
            $display("FAIL frame_restart got rd=%b x=%0d y=%0d want 1/0/0", lg_rd[72], lg_x[72], lg_y[72]); else n_pass++;
        n_total++; if ({lg_row[48], lg_row[49]} !== 2'b01)
            $display("FAIL row_update got row[48]=%0d row[49]=%0d want 0/1", lg_row[48], lg_row[49]); else n_pass++;
        n_total++; if (lg_rgb1[5] !== 3'b000) $display("FAIL rgb_plane0_col1 got %b want 000", lg_rgb1[5]); else n_pass++;
        n_total++; if (lg_rgb1[21] !== 3'b001 || lg_rgb1[22] !== 3'b001 || lg_sclk[22] !== 1'b1)
            $display("FAIL rgb_plane1_col1 got load=%b clk=%b sclk=%b want 001/001/1", lg_rgb1[21], lg_rgb1[22], lg_sclk[22]); else n_pass++;
        n_total++; if (lg_rgb1[25] !== 3'b000 || lg_rgb1[58] !== 3'b000)
            $display("FAIL rgb_other_cols got col2=%b row1col1=%b want 000/000", lg_rgb1[25], lg_rgb1[58]); else n_pass++;
        n_total++; if (n_rgb2 != 0) $display("FAIL rgb2_quiet got %0d nonzero cycles want 0", n_rgb2); else n_pass++;
    endtask

    task automatic test_brightness();
        fb_fill(6'd0, 6'd0);
        start_run(8'd127);
        run_log(72);
        n_total++; if ({lg_oe[14], lg_oe[15]} !== 2'b01)
            $display("FAIL br127_plane0 got oe[14..15]=%b%b want 01", lg_oe[14], lg_oe[15]); else n_pass++;
        n_total++; if ({lg_oe[31], lg_oe[32], lg_oe[33], lg_oe[34]} !== 4'b0011)
            $display("FAIL br127_plane1 got oe[31..34]=%b%b%b%b want 0011", lg_oe[31], lg_oe[32], lg_oe[33], lg_oe[34]); else n_pass++;
        start_run(8'd0);
        run_log(72);
        n_total++; if (count_low_oe(0, 71) != 0) $display("FAIL br0_dark got %0d low cycles want 0", count_low_oe(0, 71)); else n_pass++;
    endtask

    task automatic test_enable_drop();
        int n_done = 0;
        fb_fill(6'd0, 6'd0);
        start_run(8'd255);
        for (int t = 0; t < 130; t++) begin
            if (t == 5) enable = 1'b0;
            log_cycle(t);
            step();
        end
        for (int t = 0; t < 130; t++) if (lg_done[t] === 1'b1) n_done++;
        n_total++; if (n_done != 1 || lg_done[71] !== 1'b1) $display("FAIL drop_done got count=%0d done[71]=%b want 1/1", n_done, lg_done[71]); else n_pass++;
        n_total++; if (count_rd(0, 71) != 16) $display("FAIL drop_frame_reads got %0d want 16", count_rd(0, 71)); else n_pass++;
        n_total++; if (count_rd(72, 129) != 0 || count_low_oe(72, 129) != 0)
            $display("FAIL drop_idle got reads=%0d oe_low=%0d want 0/0", count_rd(72, 129), count_low_oe(72, 129)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        fb_fill(6'd0, 6'd0);
        start_run(8'd255);
        for (int t = 0; t < 80; t++) begin
            if (t == 5) enable = 1'b0;
            if (t == 60) enable = 1'b1;
            log_cycle(t);
            step();
        end
        n_total++; if ({lg_done[71], lg_rd[72], lg_rd[75], lg_x[75]} !== 5'b11101)
            $display("FAIL reenable_seamless got done=%b rd72=%b rd75=%b x75=%0d want 1/1/1/1", lg_done[71], lg_rd[72], lg_rd[75], lg_x[75]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        fb_fill(6'b111111, 6'b111111);
        start_run(8'd255);
        for (int t = 0; t < 50; t++) step();
        n_total++; if ({oe, row, rgb1, rgb2} !== 8'b0_1_111_111)
            $display("FAIL pre_reset got oe=%b row=%0d rgb1=%b rgb2=%b want 0/1/111/111", oe, row, rgb1, rgb2); else n_pass++;
        rst = 1'b1;
        step();
        n_total++; if ({oe, latch, sclk, pix_rd_en, row, rgb1, rgb2} !== 11'b1000_0_000_000)
            $display("FAIL mid_reset got oe=%b latch=%b sclk=%b rd=%b row=%0d rgb1=%b rgb2=%b want 1/0/0/0/0/000/000",
                     oe, latch, sclk, pix_rd_en, row, rgb1, rgb2); else n_pass++;
        rst = 1'b0; enable = 1'b1;
        step();
        run_log(20);
        n_total++; if ({lg_rd[0], lg_x[0], lg_y[0]} !== 4'b1000)
            $display("FAIL restart_fetch got rd=%b x=%0d y=%0d want 1/0/0", lg_rd[0], lg_x[0], lg_y[0]); else n_pass++;
        n_total++; if (lg_latch[13] !== 1'b1 || lg_row[13] !== 1'b0 || count_low_oe(14, 16) != 2)
            $display("FAIL restart_plane0 got latch=%b row=%0d oe_low=%0d want 1/0/2", lg_latch[13], lg_row[13], count_low_oe(14, 16)); else n_pass++;
    endtask

    task automatic test_protocol();
        int v_rdclk = 0, v_data = 0, v_latch = 0, v_row = 0, n_sclk = 0, n_done = 0, nl = 0, pl;
        logic [5:0] wt, wb;
        logic [2:0] e1, e2;
        for (int i = 0; i < 8; i++) begin
            fb_top[i] = 6'($urandom_range(0, 63));
            fb_bot[i] = 6'($urandom_range(0, 63));
        end
        start_run(8'($urandom_range(0, 255)));
        run_log(216);
        for (int t = 0; t < 216; t++) begin
            if (lg_sclk[t] === 1'b1) n_sclk++;
            if (lg_done[t] === 1'b1) n_done++;
            if (lg_latch[t] === 1'b1 && lg_oe[t] !== 1'b1) v_latch++;
            if (t > 0 && lg_row[t] !== lg_row[t-1] && lg_latch[t] !== 1'b1) v_row++;
            if (lg_rd[t] === 1'b1 && t + 2 < 216) begin
                if (lg_sclk[t] !== 1'b0 || lg_sclk[t+1] !== 1'b0 || lg_sclk[t+2] !== 1'b1) v_rdclk++;
                pl = nl % 2;
                wt = fb_top[{lg_y[t], lg_x[t]}];
                wb = fb_bot[{lg_y[t], lg_x[t]}];
                e1 = {wt[4+pl], wt[2+pl], wt[pl]};
                e2 = {wb[4+pl], wb[2+pl], wb[pl]};
                if (lg_rgb1[t+1] !== e1 || lg_rgb1[t+2] !== e1 || lg_rgb2[t+1] !== e2 || lg_rgb2[t+2] !== e2) v_data++;
            end
            if (lg_latch[t] === 1'b1) nl++;
        end
        n_total++; if (v_rdclk != 0) $display("FAIL proto_rd_to_sclk got %0d violations want 0", v_rdclk); else n_pass++;
        n_total++; if (v_data != 0) $display("FAIL proto_data got %0d wrong pixels want 0", v_data); else n_pass++;
        n_total++; if (v_latch != 0) $display("FAIL proto_latch_blanked got %0d violations want 0", v_latch); else n_pass++;
        n_total++; if (v_row != 0) $display("FAIL proto_row_change got %0d violations want 0", v_row); else n_pass++;
        n_total++; if (count_rd(0, 215) != 48 || n_sclk != 48)
            $display("FAIL proto_counts got reads=%0d sclk=%0d want 48/48", count_rd(0, 215), n_sclk); else n_pass++;
        n_total++; if (n_done != 3) $display("FAIL proto_frames got %0d frame_done want 3", n_done); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; brightness = 8'd0;
        pix_top = '0; pix_bot = '0;
        fb_fill(6'd0, 6'd0);
        test_reset();
        test_frame_timing();
        test_brightness();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_driver.md
Name: hub75_bcm_driver

Overview:
- Parametrised HUB75 LED-matrix scan driver and the next generation of the team's single-instance PWM driver.
- Reads pixels from an external synchronous frame buffer (1-cycle read latency) instead of computing colours internally.
- Drives both half-panels with binary-code-modulated (BCM) bit planes rather than linear compare-PWM.
- Adds global brightness, a run enable and a frame-done strobe; sits between the frame-buffer RAM and the panel pins.

Parameters:
- COLS, 64, pixels per row shifted per plane (≥2).
- SCAN_ROWS, 32, multiplexed row addresses (panel height/2); ROW_BITS = clog2(SCAN_ROWS).
- COLOR_BITS, 8, bits per colour channel = number of bit planes.
- BASE_TICKS, 4, display-window cycles for plane 0; plane b window W_b = BASE_TICKS<<b.

Ports:
- clk_27MHz  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled in IDLE and at frame end.
- brightness  in  8  global dimming; sampled once per plane on entry to LATCH.
- pix_rd_en  out  1  frame-buffer read strobe.
- pix_addr_x  out  clog2(COLS)  column address.
- pix_addr_y  out  ROW_BITS  row address (top half; bottom = y+SCAN_ROWS).
- pix_top  in  3*COLOR_BITS  {blue,green,red} for (x,y); valid the cycle after pix_rd_en.
- pix_bot  in  3*COLOR_BITS  {blue,green,red} for (x,y+SCAN_ROWS); same timing.
- rgb1, rgb2  out  3  {b,g,r} serial data, top/bottom half.
- row  out  ROW_BITS  panel row address.
- sclk  out  1  panel shift clock; data sampled by panel on rising edge.
- latch  out  1  panel latch, active high.
- oe  out  1  output enable, active low (1 = blanked).
- frame_done  out  1  one-cycle pulse after last plane of last row.

Behaviour:
- Reset (rst=1 at edge): state IDLE; rgb1=rgb2=0, row=0, sclk=0, latch=0, oe=1, pix_rd_en=0, addresses 0, frame_done=0. Reset mid-operation aborts immediately; no partial latch.
- Internal counters: col (0..COLS-1), cur_row (0..SCAN_ROWS-1), plane (0..COLOR_BITS-1), disp_cnt (wide enough for BASE_TICKS<<(COLOR_BITS-1)).
- States:
  - IDLE: oe=1, all other outputs held. enable=1 → FETCH with col=cur_row=plane=0.
  - FETCH: pix_rd_en=1, pix_addr_x=col, pix_addr_y=cur_row, sclk=0 → LOAD.
  - LOAD: pix_rd_en=0; rgb1[0]=pix_top[plane], rgb1[1]=pix_top[COLOR_BITS+plane], rgb1[2]=pix_top[2*COLOR_BITS+plane]; rgb2 identically from pix_bot; sclk=0 → CLK.
  - CLK: sclk=1. col==COLS-1 → BLANK with col=0; else col+1 and → FETCH.
  - BLANK: sclk=0, oe=1 → LATCH.
  - LATCH: latch=1, row=cur_row, disp_cnt=0; ON = ((BASE_TICKS<<plane)*(brightness+1))>>8 → DISPLAY.
  - DISPLAY: latch=0; oe=0 while disp_cnt<ON, else oe=1; disp_cnt increments. Leave after exactly W_b cycles in DISPLAY (disp_cnt==W_b-1) → NEXT.
  - NEXT: oe=1. Plane<COLOR_BITS-1: plane+1, → FETCH. Else plane=0; cur_row<SCAN_ROWS-1: cur_row+1, → FETCH. Else cur_row=0, frame_done=1 for this cycle; enable=1 → FETCH, else → IDLE.
- Plane timing: 3*COLS (shift) + 2 (BLANK, LATCH) + W_b (DISPLAY) + 1 (NEXT) cycles. The panel is blanked during shift; displayed light ∝ 2^plane.
- Data/sclk setup: rgb changes only in LOAD while sclk=0; stable across the sclk rising edge in CLK.
- enable deassert mid-frame: current frame completes, then IDLE. Re-assert before NEXT of the last plane: seamless continuation.
- brightness=255 → ON=W_b (full window). brightness=0 → ON=(W_b)>>8, typically 0 (fully dark).
- Counter wrap: col, cur_row and plane wrap only through the transitions above; no free-running wrap.

Test Plan:
- COLS=4, SCAN_ROWS=2, COLOR_BITS=2, BASE_TICKS=2, brightness=255, enable=1 after reset → first latch pulse at cycle 12+1 after leaving IDLE; oe low 2 cycles (plane0), then 4 cycles (plane1); frame_done after 2 rows×2 planes; frame length = (14+2+1)+(14+4+1) per row ×2 = 72 cycles.
- Frame buffer returns pix_top red=2'b10 at x=1, all else 0 → rgb1[0] high at the sclk rising edge of column 1 in plane 1 only; rgb2 stays 0.
- brightness=127, BASE_TICKS=4, plane1 (W=8) → oe low exactly 4 cycles, then high 4 cycles; brightness=0 → oe never low.
- enable dropped during row 0 → frame completes, frame_done pulses once, IDLE with oe=1, no further pix_rd_en.
- rst asserted during DISPLAY → next cycle oe=1, latch=0, sclk=0, rgb=0, row=0; after release with enable=1, restarts at row 0, plane 0.
- Protocol check over 3 random-data frames: pix_rd_en followed by a sclk rise exactly 2 cycles later; latch only while oe=1; row changes only in LATCH.
